ee354_gcd_feeder: RTL and testbench

Upstream sequencer for the ee354_GCD core.
- Buffers operand pairs in a small FIFO.
- Drives the core's Ain/Bin/Start/Ack handshake one pair at a time.
- Captures each AB_GCD result and a per-pair cycle count.
- Lets the board top, or a bench, queue several GCD jobs without hand-pulsing Start/Ack. Honours the same CEN single-step enable as the core.

---
 rtl/ee354_gcd_feeder.sv | 169 ++++++++++++++++
 tb/tb_ee354_gcd_feeder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ee354_gcd_feeder.sv
// Operand-pair FIFO plus a sequencer that drives the ee354_GCD core handshake one
// pair at a time, capturing each result and the number of enabled cycles it took.
module ee354_gcd_feeder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          CEN,
    input  logic          Push,
    input  logic [7:0]    PushA,
    input  logic [7:0]    PushB,
    output logic          Full,
    output logic          Empty,
    output logic [7:0]    Ain,
    output logic [7:0]    Bin,
    output logic          Start,
    output logic          Ack,
    input  logic          q_I,
    input  logic          q_Done,
    input  logic [7:0]    AB_GCD,
    output logic [7:0]    Res_GCD,
    output logic [CW-1:0] Res_Cycles,
    output logic          Res_Valid,
    output logic [7:0]    Jobs_Done,
    output logic          Busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        F_IDLE,
        F_LOAD,
        F_START,
        F_WAIT,
        F_ACK,
        F_REL
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     mem_q [DEPTH];
    logic [15:0]     mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      ain_q, ain_d;
    logic [7:0]      bin_q, bin_d;
    logic [7:0]      res_gcd_q, res_gcd_d;
    logic [CW-1:0]   res_cycles_q, res_cycles_d;
    logic [7:0]      jobs_q, jobs_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            pop;
    logic            push_en;
    logic [CW-1:0]   cnt_inc;
    logic [15:0]     head;

    assign Full  = (count_q == FULL_CNT);
    assign Empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ain_d        = ain_q;
        bin_d        = bin_q;
        res_gcd_d    = res_gcd_q;
        res_cycles_d = res_cycles_q;
        jobs_d       = jobs_q;
        cnt_d        = cnt_q;
        pop          = 1'b0;
        push_en      = 1'b0;
        cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

        if (CEN) begin
            case (state_q)
                F_IDLE: begin
                    if (!Empty && q_I) begin
                        pop     = 1'b1;
                        ain_d   = head[15:8];
                        bin_d   = head[7:0];
                        state_d = F_LOAD;
                    end
                end
                F_LOAD:  state_d = F_START;
                F_START: begin
                    cnt_d   = '0;
                    state_d = F_WAIT;
                end
                F_WAIT: begin
                    cnt_d = cnt_inc;
                    // Result is latched on entry to F_ACK so Res_* are already new
                    // while Res_Valid and Ack are high.
                    if (q_Done) begin
                        res_gcd_d    = AB_GCD;
                        res_cycles_d = cnt_inc;
                        jobs_d       = jobs_q + 8'd1;
                        state_d      = F_ACK;
                    end
                end
                F_ACK:   state_d = F_REL;
                F_REL: begin
                    if (q_I) begin
                        state_d = F_IDLE;
                    end
                end
                default: state_d = F_IDLE;
            endcase

            // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
            push_en = Push && (!Full || pop);
            if (push_en) begin
                mem_d[wr_ptr_q] = {PushA, PushB};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_en, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= F_IDLE;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ain_q        <= '0;
            bin_q        <= '0;
            res_gcd_q    <= '0;
            res_cycles_q <= '0;
            jobs_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ain_q        <= ain_d;
            bin_q        <= bin_d;
            res_gcd_q    <= res_gcd_d;
            res_cycles_q <= res_cycles_d;
            jobs_q       <= jobs_d;
            cnt_q        <= cnt_d;
        end
    end

    assign Ain        = ain_q;
    assign Bin        = bin_q;
    assign Start      = (state_q == F_START);
    assign Ack        = (state_q == F_ACK);
    assign Res_GCD    = res_gcd_q;
    assign Res_Cycles = res_cycles_q;
    assign Res_Valid  = CEN && (state_q == F_ACK);
    assign Jobs_Done  = jobs_q;
    assign Busy       = (state_q != F_IDLE);

endmodule

// File: tb/tb_ee354_gcd_feeder.sv
// Bench for ee354_gcd_feeder: a behavioural subtract-style GCD core answers the
// handshake; expected results are queued at push time and checked by a monitor.
module tb_ee354_gcd_feeder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 16;

    logic          Clk = 1'b0;
    logic          Reset, CEN, Push;
    logic [7:0]    PushA, PushB;
    logic          Full, Empty, Start, Ack, Res_Valid, Busy;
    logic [7:0]    Ain, Bin, Res_GCD, Jobs_Done;
    logic [CW-1:0] Res_Cycles;
    logic          q_I, q_Done;
    logic [7:0]    AB_GCD;
    logic          core_hold;

    always #5 Clk = ~Clk;

    ee354_gcd_feeder #(.DEPTH(DEPTH), .CW(CW)) dut (
        .Clk(Clk), .Reset(Reset), .CEN(CEN), .Push(Push), .PushA(PushA), .PushB(PushB),
        .Full(Full), .Empty(Empty), .Ain(Ain), .Bin(Bin), .Start(Start), .Ack(Ack),
        .q_I(q_I), .q_Done(q_Done), .AB_GCD(AB_GCD), .Res_GCD(Res_GCD),
        .Res_Cycles(Res_Cycles), .Res_Valid(Res_Valid), .Jobs_Done(Jobs_Done), .Busy(Busy)
    );

    // Behavioural core: load on Start, subtract until equal, hold Done until Ack.
    typedef enum logic [1:0] {C_I, C_SUB, C_DONE} cst_t;
    cst_t       cst;
    logic [7:0] ca, cb, cg;

    always @(posedge Clk) begin
        if (!Reset) begin
            cst <= C_I; ca <= '0; cb <= '0; cg <= '0;
        end else if (CEN) begin
            case (cst)
                C_I:    if (Start) begin ca <= Ain; cb <= Bin; cst <= C_SUB; end
                C_SUB:  if (ca == cb) begin cg <= ca; cst <= C_DONE; end
                        else if (ca > cb) ca <= ca - cb;
                        else cb <= cb - ca;
                C_DONE: if (Ack) cst <= C_I;
                default: cst <= C_I;
            endcase
        end
    end

    assign q_I    = (cst == C_I) && !core_hold;
    assign q_Done = (cst == C_DONE);
    assign AB_GCD = cg;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        int         cyc;
        logic [7:0] jobs;
    } exp_t;

    exp_t       sb[$];
    int         errs = 0;
    int         checks = 0;
    logic [7:0] jobs_sched = '0;
    int         start_cnt = 0;
    int         ack_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic [52:0] snap, prev_snap;
    logic        prev_cen;
    bit          have_prev = 0;
    bit          in_wait = 0;
    int          wait_cnt = 0;
    exp_t        e;

    assign snap = {Ain, Bin, Start, Ack, Res_GCD, Res_Cycles, Jobs_Done, Busy, Full, Empty};

    always @(negedge Clk) begin
        if (!Reset) begin
            in_wait   = 0;
            have_prev = 0;
        end else begin
            if (have_prev && !prev_cen) chk("hold_cen0", snap, prev_snap);
            if (!CEN) chk("res_valid_cen0", Res_Valid, 0);
            if (CEN) begin
                if (Start) begin
                    start_cnt++;
                    chk("start_ack_excl", Ack, 0);
                    if (sb.size() == 0) chk("start_unexpected", 1, 0);
                    else begin
                        chk("start_ain", Ain, sb[0].a);
                        chk("start_bin", Bin, sb[0].b);
                    end
                    wait_cnt = 0;
                    in_wait  = 1;
                end else if (Ack) begin
                    ack_cnt++;
                    in_wait = 0;
                end else if (in_wait) begin
                    wait_cnt++;
                end
                if (Res_Valid) begin
                    if (sb.size() == 0) chk("result_unexpected", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("res_gcd", Res_GCD, e.g);
                        chk("res_cycles_measured", Res_Cycles, wait_cnt);
                        chk("res_cycles_hand", Res_Cycles, e.cyc);
                        chk("jobs_done", Jobs_Done, e.jobs);
                    end
                end
            end
            prev_snap = snap;
            prev_cen  = CEN;
            have_prev = 1;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g, input int cyc);
        for (int i = 0; i < 200 && Full; i++) tick();
        if (Full) chk("push_wait_timeout", 1, 0);
        jobs_sched = jobs_sched + 8'd1;
        sb.push_back('{a: a, b: b, g: g, cyc: cyc, jobs: jobs_sched});
        CEN = 1'b1; Push = 1'b1; PushA = a; PushB = b;
        tick();
        Push = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !Busy && Empty) break;
            tick();
        end
        chk("drain_timeout", (sb.size() == 0) && !Busy && Empty, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int s0, a0;

    initial begin
        Reset = 1'b0; CEN = 1'b1; Push = 1'b1; PushA = 8'd1; PushB = 8'd1; core_hold = 1'b0;
        repeat (2) tick();
        chk("rst_full", Full, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_start", Start, 0);
        chk("rst_ack", Ack, 0);
        chk("rst_ain", Ain, 0);
        chk("rst_bin", Bin, 0);
        chk("rst_res_gcd", Res_GCD, 0);
        chk("rst_res_cycles", Res_Cycles, 0);
        chk("rst_res_valid", Res_Valid, 0);
        chk("rst_jobs", Jobs_Done, 0);
        chk("rst_busy", Busy, 0);
        Push = 1'b0; Reset = 1'b1;
        tick();
        chk("rst_push_ignored", Empty, 1);

        // Single job and push-to-Start latency.
        push(8'd36, 8'd24, 8'd12, 4);
        chk("lat_e0_start", Start, 0);
        tick();
        chk("lat_e1_start", Start, 0);
        tick();
        chk("lat_e2_start", Start, 1);
        chk("lat_ain", Ain, 36);
        chk("lat_bin", Bin, 24);
        wait_done(200);
        chk("single_gcd", Res_GCD, 12);
        chk("single_jobs", Jobs_Done, 1);

        // Fill FIFO while the core reports not-idle, then pop+push on full.
        s0 = start_cnt; a0 = ack_cnt;
        core_hold = 1'b1;
        push(8'd36, 8'd24, 8'd12, 4);
        push(8'd15, 8'd5, 8'd5, 4);
        push(8'd7, 8'd3, 8'd1, 6);
        push(8'h80, 8'h40, 8'h40, 3);
        chk("full_after_4", Full, 1);
        chk("hold_no_pop", Busy, 0);
        Push = 1'b1; PushA = 8'd99; PushB = 8'd33;
        tick();
        Push = 1'b0;
        chk("full_push_ignored", Full, 1);
        jobs_sched = jobs_sched + 8'd1;
        sb.push_back('{a: 8'd9, b: 8'd6, g: 8'd3, cyc: 4, jobs: jobs_sched});
        Push = 1'b1; PushA = 8'd9; PushB = 8'd6; core_hold = 1'b0;
        tick();
        Push = 1'b0;
        chk("full_pop_push", Full, 1);
        chk("full_pop_busy", Busy, 1);
        wait_done(500);
        chk("batch_starts", start_cnt - s0, 5);
        chk("batch_acks", ack_cnt - a0, 5);
        chk("batch_jobs", Jobs_Done, 6);

        // CEN toggling every cycle during one job.
        push(8'd15, 8'd5, 8'd5, 4);
        for (int i = 0; i < 60; i++) begin
            CEN = ~CEN;
            tick();
        end
        CEN = 1'b1;
        wait_done(200);
        chk("cen_gcd", Res_GCD, 5);
        chk("cen_cycles", Res_Cycles, 4);
        chk("cen_jobs", Jobs_Done, 7);

        // Reset while in F_WAIT with two pairs queued.
        push(8'd8, 8'd4, 8'd4, 3);
        push(8'd8, 8'd4, 8'd4, 3);
        push(8'd8, 8'd4, 8'd4, 3);
        for (int i = 0; i < 50 && !Start; i++) tick();
        chk("mid_start_seen", Start, 1);
        tick();
        chk("mid_in_wait", Busy && !Start && !Ack, 1);
        Reset = 1'b0;
        tick();
        chk("mid_busy", Busy, 0);
        chk("mid_empty", Empty, 1);
        chk("mid_full", Full, 0);
        chk("mid_start", Start, 0);
        chk("mid_ack", Ack, 0);
        chk("mid_res_valid", Res_Valid, 0);
        chk("mid_jobs", Jobs_Done, 0);
        Reset = 1'b1;
        sb.delete();
        jobs_sched = '0;
        repeat (20) tick();
        chk("mid_no_result", Jobs_Done, 0);
        chk("mid_still_idle", Busy, 0);

        // 256 jobs wrap the completed-job counter.
        for (int i = 0; i < 256; i++) push(8'd8, 8'd4, 8'd4, 3);
        wait_done(2000);
        chk("wrap_jobs", Jobs_Done, 0);
        chk("wrap_gcd", Res_GCD, 4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
